// File: rtl/rv_id_pkg.sv
// Shared decode constants, immediate formats and the decoded-control bundle
// used by the RV32I decode stage.
package rv_id_pkg;

    localparam logic [5:0] ALU_NONE  = 6'd0;
    localparam logic [5:0] ALU_ADD   = 6'd1;
    localparam logic [5:0] ALU_SUB   = 6'd2;
    localparam logic [5:0] ALU_SLL   = 6'd3;
    localparam logic [5:0] ALU_JAL   = 6'd4;
    localparam logic [5:0] ALU_ADDI  = 6'd5;
    localparam logic [5:0] ALU_AND   = 6'd6;
    localparam logic [5:0] ALU_OR    = 6'd7;
    localparam logic [5:0] ALU_XOR   = 6'd8;
    localparam logic [5:0] ALU_BLT   = 6'd9;
    localparam logic [5:0] ALU_BEQ   = 6'd10;
    localparam logic [5:0] ALU_SRL   = 6'd11;
    localparam logic [5:0] ALU_LW    = 6'd12;
    localparam logic [5:0] ALU_SW    = 6'd13;
    localparam logic [5:0] ALU_LUI   = 6'd14;
    localparam logic [5:0] ALU_AUIPC = 6'd15;
    localparam logic [5:0] ALU_JALR  = 6'd16;
    localparam logic [5:0] ALU_BNE   = 6'd17;
    localparam logic [5:0] ALU_SLT   = 6'd18;
    localparam logic [5:0] ALU_SRA   = 6'd19;
    localparam logic [5:0] ALU_ANDI  = 6'd20;
    localparam logic [5:0] ALU_ORI   = 6'd21;
    localparam logic [5:0] ALU_XORI  = 6'd22;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_JALR = 3'b000;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [5:0] aluop;
        imm_fmt_e   fmt;
        logic       reg_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       branch;
        logic       jump;
        logic       illegal;
        logic       use_rs1;
        logic       use_rs2;
    } dec_t;

    // Canonical "unrecognised instruction" bundle: no side effects, illegal flagged.
    function automatic dec_t dec_none();
        dec_t d;
        d.aluop   = ALU_NONE;
        d.fmt     = IMM_NONE;
        d.reg_we  = 1'b0;
        d.mem_rd  = 1'b0;
        d.mem_wr  = 1'b0;
        d.branch  = 1'b0;
        d.jump    = 1'b0;
        d.illegal = 1'b1;
        d.use_rs1 = 1'b0;
        d.use_rs2 = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator: extracts the I/S/B/U/J immediate of an
// RV32I instruction and sign-extends it from bit 31 to XLEN.
module rv_imm_gen
    import rv_id_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32_s;
    logic        unused_opcode_s;

    assign unused_opcode_s = ^instr[6:0];

    // Assemble the 32-bit immediate for the selected format
    always_comb begin
        imm32_s = 32'd0;
        case (fmt)
            IMM_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32_s = {instr[31:12], 12'd0};
            IMM_J:   imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_NONE: imm32_s = 32'd0;
            default: imm32_s = 32'd0;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_wide
            assign imm = {{(XLEN-32){imm32_s[31]}}, imm32_s};
        end else begin : g_narrow
            assign imm = imm32_s;
        end
    endgenerate

endmodule

// File: rtl/id_stage.sv
// Registered RV32I decode stage: valid/ready input from fetch, one-cycle
// decode into a holding register for execute, with load-use bubble insertion.
module id_stage
    import rv_id_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ALUOP_W  = 6,
    parameter int LOAD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic [4:0]         out_rs1,
    output logic [4:0]         out_rs2,
    output logic [4:0]         out_rd,
    output logic [XLEN-1:0]    out_imm,
    output logic               out_reg_we,
    output logic               out_mem_rd,
    output logic               out_mem_wr,
    output logic               out_branch,
    output logic               out_jump,
    output logic               out_illegal
);

    localparam logic [1:0] BUBBLES = 2'(LOAD_LAT - 1);

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [4:0]      rd_s;
    dec_t            dec_s;
    logic [XLEN-1:0] imm_s;
    logic            hazard_s;
    logic            accept_s;
    logic            consume_s;
    logic            in_ready_s;

    logic               out_valid_r;
    logic [1:0]         bcnt_r;
    logic [XLEN-1:0]    out_pc_r;
    logic [ALUOP_W-1:0] out_aluop_r;
    logic [4:0]         out_rs1_r;
    logic [4:0]         out_rs2_r;
    logic [4:0]         out_rd_r;
    logic [XLEN-1:0]    out_imm_r;
    logic               out_reg_we_r;
    logic               out_mem_rd_r;
    logic               out_mem_wr_r;
    logic               out_branch_r;
    logic               out_jump_r;
    logic               out_illegal_r;

    assign opcode_s = in_instr[6:0];
    assign funct3_s = in_instr[14:12];
    assign funct7_s = in_instr[31:25];
    assign rs1_s    = in_instr[19:15];
    assign rs2_s    = in_instr[24:20];
    assign rd_s     = in_instr[11:7];

    // Decode the incoming instruction into ALUop, immediate format and control flags
    always_comb begin
        dec_s = dec_none();
        case (opcode_s)
            OPC_OP: begin
                dec_s.reg_we  = 1'b1;
                dec_s.use_rs1 = 1'b1;
                dec_s.use_rs2 = 1'b1;
                case ({funct7_s, funct3_s})
                    {F7_BASE, F3_ADD}: dec_s.aluop = ALU_ADD;
                    {F7_ALT,  F3_ADD}: dec_s.aluop = ALU_SUB;
                    {F7_BASE, F3_SLL}: dec_s.aluop = ALU_SLL;
                    {F7_BASE, F3_SLT}: dec_s.aluop = ALU_SLT;
                    {F7_BASE, F3_XOR}: dec_s.aluop = ALU_XOR;
                    {F7_BASE, F3_SR}:  dec_s.aluop = ALU_SRL;
                    {F7_ALT,  F3_SR}:  dec_s.aluop = ALU_SRA;
                    {F7_BASE, F3_OR}:  dec_s.aluop = ALU_OR;
                    {F7_BASE, F3_AND}: dec_s.aluop = ALU_AND;
                    default:           dec_s.aluop = ALU_NONE;
                endcase
            end
            OPC_OPIMM: begin
                dec_s.fmt     = IMM_I;
                dec_s.reg_we  = 1'b1;
                dec_s.use_rs1 = 1'b1;
                case (funct3_s)
                    F3_ADD:  dec_s.aluop = ALU_ADDI;
                    F3_XOR:  dec_s.aluop = ALU_XORI;
                    F3_OR:   dec_s.aluop = ALU_ORI;
                    F3_AND:  dec_s.aluop = ALU_ANDI;
                    default: dec_s.aluop = ALU_NONE;
                endcase
            end
            OPC_LOAD: begin
                dec_s.fmt     = IMM_I;
                dec_s.reg_we  = 1'b1;
                dec_s.mem_rd  = 1'b1;
                dec_s.use_rs1 = 1'b1;
                if (funct3_s == F3_W) dec_s.aluop = ALU_LW;
                else                  dec_s.aluop = ALU_NONE;
            end
            OPC_STORE: begin
                dec_s.fmt     = IMM_S;
                dec_s.mem_wr  = 1'b1;
                dec_s.use_rs1 = 1'b1;
                dec_s.use_rs2 = 1'b1;
                if (funct3_s == F3_W) dec_s.aluop = ALU_SW;
                else                  dec_s.aluop = ALU_NONE;
            end
            OPC_BRANCH: begin
                dec_s.fmt     = IMM_B;
                dec_s.branch  = 1'b1;
                dec_s.use_rs1 = 1'b1;
                dec_s.use_rs2 = 1'b1;
                case (funct3_s)
                    F3_BEQ:  dec_s.aluop = ALU_BEQ;
                    F3_BNE:  dec_s.aluop = ALU_BNE;
                    F3_BLT:  dec_s.aluop = ALU_BLT;
                    default: dec_s.aluop = ALU_NONE;
                endcase
            end
            OPC_JAL: begin
                dec_s.fmt    = IMM_J;
                dec_s.reg_we = 1'b1;
                dec_s.jump   = 1'b1;
                dec_s.aluop  = ALU_JAL;
            end
            OPC_JALR: begin
                dec_s.fmt     = IMM_I;
                dec_s.reg_we  = 1'b1;
                dec_s.jump    = 1'b1;
                dec_s.use_rs1 = 1'b1;
                if (funct3_s == F3_JALR) dec_s.aluop = ALU_JALR;
                else                     dec_s.aluop = ALU_NONE;
            end
            OPC_LUI: begin
                dec_s.fmt    = IMM_U;
                dec_s.reg_we = 1'b1;
                dec_s.aluop  = ALU_LUI;
            end
            OPC_AUIPC: begin
                dec_s.fmt    = IMM_U;
                dec_s.reg_we = 1'b1;
                dec_s.aluop  = ALU_AUIPC;
            end
            default: dec_s = dec_none();
        endcase
        // Unrecognised funct fields collapse to the side-effect-free illegal bundle
        if (dec_s.aluop == ALU_NONE) begin
            dec_s = dec_none();
        end else begin
            dec_s.illegal = 1'b0;
            dec_s.reg_we  = dec_s.reg_we & (rd_s != 5'd0);
        end
    end

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr),
        .fmt   (dec_s.fmt),
        .imm   (imm_s)
    );

    // Only the held instruction is compared; anything already consumed is out of reach
    assign hazard_s = out_valid_r && out_mem_rd_r && (out_rd_r != 5'd0) && in_valid &&
                      ((dec_s.use_rs1 && (rs1_s == out_rd_r)) ||
                       (dec_s.use_rs2 && (rs2_s == out_rd_r)));

    assign in_ready_s = !flush && (bcnt_r == 2'd0) && !hazard_s && (!out_valid_r || out_ready);
    assign accept_s   = in_valid && in_ready_s;
    assign consume_s  = out_valid_r && out_ready;

    // Output-valid flag and load-use bubble counter
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            bcnt_r      <= 2'd0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
            bcnt_r      <= 2'd0;
        end else begin
            if (accept_s) begin
                out_valid_r <= 1'b1;
            end else if (consume_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (hazard_s && consume_s) begin
                bcnt_r <= BUBBLES;
            end else if (bcnt_r != 2'd0) begin
                bcnt_r <= bcnt_r - 2'd1;
            end else begin
                bcnt_r <= bcnt_r;
            end
        end
    end

    // Decoded payload register, loaded only on an accepted instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pc_r      <= {XLEN{1'b0}};
            out_aluop_r   <= {ALUOP_W{1'b0}};
            out_rs1_r     <= 5'd0;
            out_rs2_r     <= 5'd0;
            out_rd_r      <= 5'd0;
            out_imm_r     <= {XLEN{1'b0}};
            out_reg_we_r  <= 1'b0;
            out_mem_rd_r  <= 1'b0;
            out_mem_wr_r  <= 1'b0;
            out_branch_r  <= 1'b0;
            out_jump_r    <= 1'b0;
            out_illegal_r <= 1'b0;
        end else if (accept_s) begin
            out_pc_r      <= in_pc;
            out_aluop_r   <= ALUOP_W'(dec_s.aluop);
            out_rs1_r     <= rs1_s;
            out_rs2_r     <= rs2_s;
            out_rd_r      <= rd_s;
            out_imm_r     <= imm_s;
            out_reg_we_r  <= dec_s.reg_we;
            out_mem_rd_r  <= dec_s.mem_rd;
            out_mem_wr_r  <= dec_s.mem_wr;
            out_branch_r  <= dec_s.branch;
            out_jump_r    <= dec_s.jump;
            out_illegal_r <= dec_s.illegal;
        end else begin
            out_pc_r      <= out_pc_r;
            out_aluop_r   <= out_aluop_r;
            out_rs1_r     <= out_rs1_r;
            out_rs2_r     <= out_rs2_r;
            out_rd_r      <= out_rd_r;
            out_imm_r     <= out_imm_r;
            out_reg_we_r  <= out_reg_we_r;
            out_mem_rd_r  <= out_mem_rd_r;
            out_mem_wr_r  <= out_mem_wr_r;
            out_branch_r  <= out_branch_r;
            out_jump_r    <= out_jump_r;
            out_illegal_r <= out_illegal_r;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_pc      = out_pc_r;
    assign out_aluop   = out_aluop_r;
    assign out_rs1     = out_rs1_r;
    assign out_rs2     = out_rs2_r;
    assign out_rd      = out_rd_r;
    assign out_imm     = out_imm_r;
    assign out_reg_we  = out_reg_we_r;
    assign out_mem_rd  = out_mem_rd_r;
    assign out_mem_wr  = out_mem_wr_r;
    assign out_branch  = out_branch_r;
    assign out_jump    = out_jump_r;
    assign out_illegal = out_illegal_r;

endmodule

// File: doc/id_stage.md
# id_stage

Registered RV32I decode stage, the pipelined successor to the single-cycle combinational decoder. It accepts a fetched instruction and PC over a valid/ready handshake and decodes opcode/funct3/funct7 into an ALUop, register indices, a sign-extended immediate and control flags. It registers the result for the execute stage and inserts a configurable number of load-use bubbles. It sits between the fetch stage and the execute stage; the register file is read downstream using `out_rs1`/`out_rs2`.

## Interface

- `XLEN`, 32: datapath/PC/immediate width; allowed values 32 or 64.
- `ALUOP_W`, 6: ALUop width.
- `LOAD_LAT`, 1: bubbles inserted on a load-use hazard; range 1–3.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: kill the held instruction and the current input (taken branch/jump).
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `in_instr` in 32: instruction word.
- `in_pc` in XLEN: instruction PC.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_pc` out XLEN.
- `out_aluop` out ALUOP_W.
- `out_rs1`, `out_rs2`, `out_rd` out 5.
- `out_imm` out XLEN.
- `out_reg_we`, `out_mem_rd`, `out_mem_wr`, `out_branch`, `out_jump`, `out_illegal` out 1 each.

## Operation

- ALUop codes (0 = illegal/none):
  - add 1, sub 2, sll 3, jal 4, addi 5, and 6, or 7, xor 8.
  - blt 9, beq 10, srl 11, lw 12, sw 13.
  - lui 14, auipc 15, jalr 16, bne 17, slt 18, sra 19, andi 20, ori 21, xori 22.
- Decoding uses standard RV32I encodings:
  - OP 0110011 (funct7 0000000 or 0100000 as applicable).
  - OP-IMM 0010011.
  - LOAD 0000011 with funct3 010.
  - STORE 0100011 with funct3 010.
  - BRANCH 1100011 (funct3 000 beq, 001 bne, 100 blt).
  - JAL 1101111, JALR 1100111 with funct3 000.
  - LUI 0110111, AUIPC 0010111.
- Any other encoding gives ALUop 0 and `out_illegal`=1; `out_reg_we`, `out_mem_rd`, `out_mem_wr`, `out_branch`, `out_jump` are all 0.
- Immediates are sign-extended from bit 31 to XLEN:
  - I-type for OP-IMM, LOAD, JALR.
  - S-type for STORE.
  - B-type for BRANCH.
  - U-type for LUI/AUIPC (`{instr[31:12],12'b0}`, then sign-extended).
  - J-type for JAL.
  - 0 for OP.
- `out_reg_we` = 1 for OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC, and forced to 0 when rd = x0.
- `out_rs1`/`out_rs2`/`out_rd` always carry raw `instr[19:15]`/`instr[24:20]`/`instr[11:7]`. The "uses rs1/rs2" flags are internal only.
- Load-use hazard: the output register holds a valid load with rd≠0, and the incoming valid instruction uses that register as rs1 or rs2.
  - On hazard, `in_ready`=0.
  - When the load is consumed (`out_valid && out_ready`), the output register goes invalid and bubble counter `bcnt` loads `LOAD_LAT-1`.
  - While `bcnt`≠0, `in_ready`=0 and `bcnt` decrements each cycle.
  - Once `bcnt`=0 and no hazard exists, the instruction is accepted.
- `in_ready` = `!flush && bcnt==0 && !hazard && (!out_valid || out_ready)`.

## Timing

- Latency: one cycle from `in_valid && in_ready` to `out_valid` with the decoded fields.
- Outputs are held stable while `out_valid && !out_ready`.
- Reset: `out_valid`=0, every other output 0 (`out_aluop`=0, `out_illegal`=0), `bcnt`=0. Reset takes priority over `flush`.
- `flush`:
  - Next cycle `out_valid`=0 and `bcnt`=0.
  - The input in the flush cycle is not accepted, since `in_ready`=0.
  - Flush overrides any simultaneous consume or accept.
- Back-to-back: with `out_ready` held at 1 and no hazard, throughput is one instruction per cycle.
- Simultaneous consume and accept in the same cycle is legal; the register is overwritten with the new instruction.
- A hazard is checked only against the held instruction. An instruction separated from the load by an accepted non-dependent instruction is not stalled.

## Structure

- Package `rv_id_pkg` holds:
  - ALUop localparams.
  - Opcode and funct constants.
  - Immediate-format enum (`IMM_I`, `IMM_S`, `IMM_B`, `IMM_U`, `IMM_J`, `IMM_NONE`).
- Sub-module `rv_imm_gen` (combinational): takes `instr` and the format, returns the XLEN sign-extended immediate.
- `id_stage` contains the decode case, hazard logic, `bcnt`, and the output register.

## Test plan

- Reset: drive `rst`=1 for 2 cycles, then release. All outputs are 0 and `in_ready`=1.
- Decode sweep:
  - `0x00208033` (add x0,x1,x2): ALUop 1, `out_reg_we`=0 (rd = x0).
  - `0xFFF00093` (addi x1,x0,-1): ALUop 5, `out_imm`=`0xFFFFFFFF`, `out_reg_we`=1.
  - `0x00000000`: ALUop 0, `out_illegal`=1.
- Load-use with `LOAD_LAT`=2:
  - Sequence: lw x5,0(x1) then add x6,x5,x2, with `out_ready`=1.
  - Required: exactly 2 cycles of `out_valid`=0 between the two instructions; the add appears 3 cycles after the lw.
- Backpressure: `out_ready`=0 for 5 cycles while issuing beq (`0x00208463`). The held outputs stay unchanged (ALUop 10, `out_imm`=8) and `in_ready`=0.
- Flush: assert `flush` in the same cycle as a consume plus a new input. Next cycle `out_valid`=0; the new instruction is not accepted and must be re-presented.
- Independent load: lw x5 then add x6,x7,x8. No bubble inserted; the instructions issue on consecutive cycles.
